// File: rtl/score_display_ctrl.sv
// score_display_ctrl: pong match FSM and 8x8 dot-matrix scan driver; define DOT_GHOST_BLANK_EN to add per-row ghost blanking
module score_display_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int ROW_HZ       = 10000,
  parameter int WIN_SCORE    = 3,
  parameter int HOLD_ROWS    = 5000,
  parameter int FLASH_ROWS   = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       left_wall_hit,
  input  logic       right_wall_hit,
  input  logic       start,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col,
  output logic [1:0] left_score,
  output logic [1:0] right_score,
  output logic [1:0] winner,
  output logic       game_active
);
  localparam int DIV = CLK_HZ / ROW_HZ;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HW  = $clog2(HOLD_ROWS + 1);
  localparam int FW  = $clog2(FLASH_ROWS + 1);
  localparam logic [1:0] WS = 2'(WIN_SCORE);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_WIN} state_t;

  state_t          r_state;
  logic [2:0]      r_in_s1, r_in_s2, r_in_d, r_pulse;
  logic [PW-1:0]   r_pre;
  logic [2:0]      r_row_idx;
  logic [HW-1:0]   r_hold_cnt;
  logic [FW-1:0]   r_flash_cnt;
  logic            r_flash;
  logic            w_tick, w_centre, w_l_pulse, w_r_pulse, w_s_pulse;
  logic [1:0]      w_l_inc, w_r_inc;
  logic [7:0]      w_row, w_norm, w_win, w_pat;

  assign w_tick    = r_pre == PW'(DIV - 1);
  assign w_l_pulse = r_pulse[0];
  assign w_r_pulse = r_pulse[1];
  assign w_s_pulse = r_pulse[2];
  assign w_l_inc   = &left_score ? 2'd3 : left_score + 2'd1;
  assign w_r_inc   = &right_score ? 2'd3 : right_score + 2'd1;
  assign w_centre  = r_row_idx[1] ^ r_row_idx[0];
  assign w_row     = ~(8'h80 >> r_row_idx);
  assign w_norm    = {|left_score, left_score[1], &left_score, {2{w_centre}},
                      &right_score, right_score[1], |right_score};
  assign w_win     = !r_flash ? 8'h00 : winner == 2'b01 ? 8'hE0 : winner == 2'b10 ? 8'h07 : 8'h00;
  assign w_pat     = r_state == S_WIN ? w_win : w_norm;

  // synchronise the {start, right, left} levels and turn rising edges into 1-cycle pulses
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_in_s1 <= '0;
      r_in_s2 <= '0;
      r_in_d  <= '0;
      r_pulse <= '0;
    end else begin
      r_in_s1 <= {start, right_wall_hit, left_wall_hit};
      r_in_s2 <= r_in_s1;
      r_in_d  <= r_in_s2;
      r_pulse <= r_in_s2 & ~r_in_d;
    end
  end

  // row-rate prescaler and pointer to the row shown at the next tick
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_pre     <= '0;
      r_row_idx <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_row_idx <= r_row_idx + 3'd1;
    end
  end

`ifdef DOT_GHOST_BLANK_EN
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  logic [BW-1:0] r_blank;
  logic [7:0]    r_nxt_row, r_nxt_col;

  // dark the matrix for BLANK_CYCLES after each tick, then show the captured row
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      dot_row   <= 8'hFF;
      dot_col   <= '0;
      r_nxt_row <= 8'hFF;
      r_nxt_col <= '0;
      r_blank   <= '0;
    end else if (w_tick) begin
      dot_row   <= 8'hFF;
      dot_col   <= '0;
      r_nxt_row <= w_row;
      r_nxt_col <= w_pat;
      r_blank   <= BW'(BLANK_CYCLES);
    end else if (r_blank != '0) begin
      r_blank <= r_blank - 1'b1;
      if (r_blank == BW'(1)) begin
        dot_row <= r_nxt_row;
        dot_col <= r_nxt_col;
      end
    end
  end
`else
  // drive the new row and its column pattern on the tick itself
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      dot_row <= 8'hFF;
      dot_col <= '0;
    end else if (w_tick) begin
      dot_row <= w_row;
      dot_col <= w_pat;
    end
  end
`endif

  // match flow: scoring, post-point hold, win flash and restart
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      left_score  <= '0;
      right_score <= '0;
      winner      <= '0;
      game_active <= 1'b0;
      r_hold_cnt  <= '0;
      r_flash_cnt <= '0;
      r_flash     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_s_pulse) begin
          r_state     <= S_PLAY;
          game_active <= 1'b1;
        end
        S_PLAY: if (w_l_pulse || w_r_pulse) begin
          game_active <= 1'b0;
          r_hold_cnt  <= '0;
          r_flash_cnt <= '0;
          r_flash     <= 1'b1;
          if (w_l_pulse) begin
            left_score <= w_l_inc;
            r_state    <= w_l_inc == WS ? S_WIN : S_HOLD;
            winner     <= w_l_inc == WS ? 2'b01 : 2'b00;
          end else begin
            right_score <= w_r_inc;
            r_state     <= w_r_inc == WS ? S_WIN : S_HOLD;
            winner      <= w_r_inc == WS ? 2'b10 : 2'b00;
          end
        end
        S_HOLD: if (w_tick) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (r_hold_cnt == HW'(HOLD_ROWS - 1)) begin
            r_state     <= S_PLAY;
            game_active <= 1'b1;
          end
        end
        S_WIN: if (w_s_pulse) begin
          r_state     <= S_PLAY;
          left_score  <= '0;
          right_score <= '0;
          winner      <= '0;
          game_active <= 1'b1;
        end else if (w_tick) begin
          r_flash_cnt <= r_flash_cnt == FW'(FLASH_ROWS - 1) ? '0 : r_flash_cnt + 1'b1;
          if (r_flash_cnt == FW'(FLASH_ROWS - 1)) r_flash <= ~r_flash;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed checks of scan, scoring, hold, win flash and async reset
module tb_score_display_ctrl;
  logic       clk = 1'b0;
  logic       reset, lh, rh, st;
  logic [7:0] dot_row, dot_col;
  logic [1:0] left_score, right_score, winner;
  logic       game_active;
  int         n_chk = 0;
  int         n_err = 0;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
  } vec_t;

  vec_t       scan_tab[9];
  logic [7:0] flash_tab[8];

  score_display_ctrl #(
    .CLK_HZ(80), .ROW_HZ(10), .WIN_SCORE(3), .HOLD_ROWS(4), .FLASH_ROWS(2), .BLANK_CYCLES(2)
  ) dut (
    .clk_50MHz(clk), .reset(reset), .left_wall_hit(lh), .right_wall_hit(rh), .start(st),
    .dot_row(dot_row), .dot_col(dot_col), .left_score(left_score), .right_score(right_score),
    .winner(winner), .game_active(game_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    logic [7:0] prev;
    int c;
    for (int k = 0; k < n; k++) begin
      prev = dot_row;
      c = 0;
      do begin
        @(posedge clk);
        #1;
        c++;
      end while (dot_row === prev && c < 20);
      if (dot_row === prev) begin
        n_chk++;
        n_err++;
        $display("FAIL tick_timeout: dot_row stuck at %h", dot_row);
      end
    end
  endtask

  task automatic wait_row(input logic [7:0] r);
    for (int k = 0; k < 9 && dot_row !== r; k++) wait_ticks(1);
    chk("row_sync", dot_row, r);
  endtask

  task automatic wait_active();
    int c = 0;
    while (game_active !== 1'b1 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("resume_play", 8'(game_active), 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    scan_tab[0] = '{8'h7F, 8'h00};
    scan_tab[1] = '{8'hBF, 8'h18};
    scan_tab[2] = '{8'hDF, 8'h18};
    scan_tab[3] = '{8'hEF, 8'h00};
    scan_tab[4] = '{8'hF7, 8'h00};
    scan_tab[5] = '{8'hFB, 8'h18};
    scan_tab[6] = '{8'hFD, 8'h18};
    scan_tab[7] = '{8'hFE, 8'h00};
    scan_tab[8] = '{8'h7F, 8'h00};
    flash_tab   = '{8'h07, 8'h07, 8'h00, 8'h00, 8'h07, 8'h07, 8'h00, 8'h00};
    reset = 1'b1; lh = 1'b0; rh = 1'b0; st = 1'b0;
    #2;
    chk("rst_row", dot_row, 8'hFF);
    chk("rst_col", dot_col, 8'h00);
    chk("rst_l", 8'(left_score), 8'h00);
    chk("rst_active", 8'(game_active), 8'h00);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("scan_row%0d", i), dot_row, scan_tab[i].row);
      chk($sformatf("scan_col%0d", i), dot_col, scan_tab[i].col);
    end
    @(negedge clk) st = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("start_play", 8'(game_active), 8'h01);
    @(negedge clk) st = 1'b0;
    lh = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("left_lat3", 8'(left_score), 8'h00);
    @(posedge clk);
    #1;
    chk("left_lat4", 8'(left_score), 8'h01);
    chk("hold_inactive", 8'(game_active), 8'h00);
    @(negedge clk) rh = 1'b1;
    wait_ticks(3);
    chk("hold_3ticks", 8'(game_active), 8'h00);
    wait_ticks(1);
    chk("hold_done", 8'(game_active), 8'h01);
    chk("hold_ignore_r", 8'(right_score), 8'h00);
    @(negedge clk) begin lh = 1'b0; rh = 1'b0; end
    wait_row(8'h7F);
    chk("l1_row0_col", dot_col, 8'h80);
    wait_ticks(1);
    chk("l1_row1", dot_row, 8'hBF);
    chk("l1_row1_col", dot_col, 8'h98);
    @(negedge clk) begin lh = 1'b1; rh = 1'b1; end
    repeat (4) @(posedge clk);
    #1;
    chk("simul_l", 8'(left_score), 8'h02);
    chk("simul_r", 8'(right_score), 8'h00);
    @(negedge clk) begin lh = 1'b0; rh = 1'b0; end
    wait_ticks(1);
    @(negedge clk);
    chk("pre_rst_hold", 8'(game_active), 8'h00);
    reset = 1'b1;
    #1;
    chk("arst_row", dot_row, 8'hFF);
    chk("arst_col", dot_col, 8'h00);
    chk("arst_l", 8'(left_score), 8'h00);
    chk("arst_r", 8'(right_score), 8'h00);
    chk("arst_win", 8'(winner), 8'h00);
    chk("arst_active", 8'(game_active), 8'h00);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) lh = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_ignore_l", 8'(left_score), 8'h00);
    chk("idle_inactive", 8'(game_active), 8'h00);
    @(negedge clk) lh = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) st = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("restart_play", 8'(game_active), 8'h01);
    @(negedge clk) st = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      @(negedge clk) rh = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("right_pt%0d", p), 8'(right_score), 8'(p));
      @(negedge clk) rh = 1'b0;
      if (p < 3) wait_active();
    end
    chk("win_winner", 8'(winner), 8'h02);
    chk("win_inactive", 8'(game_active), 8'h00);
    for (int i = 0; i < 8; i++) begin
      wait_ticks(1);
      chk($sformatf("flash%0d", i), dot_col, flash_tab[i]);
    end
    @(negedge clk) st = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rematch_l", 8'(left_score), 8'h00);
    chk("rematch_r", 8'(right_score), 8'h00);
    chk("rematch_win", 8'(winner), 8'h00);
    chk("rematch_active", 8'(game_active), 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
